ripple_carry_adder_4bit: RTL and testbench
==========================================

// Module: ripple_carry_adder_4bit
// PURPOSE
//   Registered N-bit (default 4) ripple-carry adder: sum/carry = a + b + cin.
//   Datapath is an explicit chain of 1-bit full adders with no carry lookahead.
//   The result is captured in output registers on each valid-qualified clock edge.
//   Leaf arithmetic block for small datapaths that need a registered add result.
// PARAMETERS
//   WIDTH    4    operand/sum width in bits (>=1)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      reset, asynchronous assert, active-low
//   in_valid   in   1      operands valid this cycle; qualifies capture
//   a          in   WIDTH  operand A, unsigned
//   b          in   WIDTH  operand B, unsigned
//   cin        in   1      carry-in to bit 0
//   sum        out  WIDTH  registered sum[WIDTH-1:0]
//   carry      out  1      registered carry-out of MSB full adder
//   overflow   out  1      registered signed overflow (two's-complement view)
//   out_valid  out  1      high for one cycle when sum/carry hold a new result
// BEHAVIOUR
//   - Reset: rst_n low drives sum=0, carry=0, overflow=0 and out_valid=0
//     immediately, with no clock required. Release is synchronous to clk.
//   - Per-bit full adder: s[i] = a[i]^b[i]^c[i];
//     c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = cin.
//   - Result identity: {carry,sum} == a + b + cin, computed at WIDTH+1 bits.
//     No truncation except as shown; max 15+15+1 = 31 -> carry=1, sum=15.
//   - overflow = c[WIDTH] ^ c[WIDTH-1]. It is meaningful for signed operands
//     and is always produced.
//   - Latency: 1 cycle. Operands are sampled at posedge where in_valid=1.
//     Results appear after that edge. out_valid=1 for exactly that following cycle.
//   - in_valid=0: sum/carry/overflow hold their last value; out_valid=0.
//   - Back-to-back in_valid: a new result every cycle; throughput 1/clk.
//   - The datapath is purely combinational between input pins and the output
//     registers. There are no input registers.
//   - Reset asserted mid-stream: any pending result is discarded, outputs go
//     to 0, and the first valid after release is processed normally.
//   - X on a/b/cin while in_valid=0 must not corrupt the held outputs.
// TESTING
//   1) rst_n=0, in_valid=x, any operands -> sum=0, carry=0, overflow=0,
//      out_valid=0, asynchronously.
//   2) Directed set, one per cycle, in_valid=1. Each produces the listed
//      result one clock later with out_valid=1:
//      - a=0,  b=0, cin=0 -> sum=0,  carry=0
//      - a=1,  b=2, cin=0 -> sum=3,  carry=0
//      - a=5,  b=3, cin=1 -> sum=9,  carry=0, overflow=1
//      - a=15, b=15, cin=1 -> sum=15, carry=1, overflow=0
//      - a=10, b=5, cin=0 -> sum=15, carry=0
//      - a=12, b=3, cin=1 -> sum=0,  carry=1 (full carry ripple through all bits)
//   3) Hold check: after a=1, b=2 result, drop in_valid and change operands to
//      a=9, b=9 -> sum stays 3, out_valid=0.
//   4) Signed overflow: a=7, b=1, cin=0 -> sum=8, carry=0, overflow=1;
//      a=8, b=8 -> sum=0, carry=1, overflow=1.
//   5) Reset mid-stream: assert rst_n between two valid cycles -> outputs
//      clear at once; the next valid a=2, b=2 gives sum=4 one cycle after release.
//   6) Exhaustive: all 512 (a,b,cin) combinations checked against
//      {carry,sum} == a+b+cin.

Source files
------------

// File: rtl/ripple_carry_adder_4bit_if.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder_4bit_if
//
// Purpose:
//   Bundles the operand/result signals of the registered ripple-carry adder
//   so that the adder and its user connect through one port.
//
// Signals:
//   in_valid   master -> slave  operands valid this cycle
//   a          master -> slave  operand A, unsigned, WIDTH bits
//   b          master -> slave  operand B, unsigned, WIDTH bits
//   cin        master -> slave  carry-in to bit 0
//   sum        slave -> master  registered sum, WIDTH bits
//   carry      slave -> master  registered carry-out of the MSB
//   overflow   slave -> master  registered two's-complement overflow
//   out_valid  slave -> master  one-cycle pulse when a new result is held
//
// Modports:
//   master  the block that supplies operands and consumes results
//   slave   the adder itself
// ---------------------------------------------------------------------------
interface ripple_carry_adder_4bit_if #(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             out_valid;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        input  sum,
        input  carry,
        input  overflow,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        output sum,
        output carry,
        output overflow,
        output out_valid
    );

endinterface

// File: rtl/ripple_carry_adder_4bit.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder_4bit
//
// Purpose:
//   Registered WIDTH-bit ripple-carry adder computing {carry,sum} = a+b+cin.
//   The datapath is an explicit chain of 1-bit full adders (no lookahead)
//   feeding output registers that capture on each clock edge where
//   in_valid is high. There are no input registers, so latency is one cycle
//   and throughput is one result per clock.
//
// Parameters:
//   WIDTH      operand/sum width in bits (>= 1), default 4
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous assert, active-low reset
//   adder      slave modport of ripple_carry_adder_4bit_if
//                (in_valid, a, b, cin in; sum, carry, overflow, out_valid out)
// ---------------------------------------------------------------------------

// One full-adder cell of the ripple chain.
module FullAdderCell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic propagate;

    // Carry is generated by a&b or propagated from the incoming carry when
    // exactly one operand bit is set.
    assign propagate = a_i ^ b_i;
    assign s_o       = propagate ^ c_i;
    assign c_o       = (a_i & b_i) | (c_i & propagate);

endmodule

module ripple_carry_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ripple_carry_adder_4bit_if.slave       adder
);

    // carryChain[i] is the carry into bit i; carryChain[WIDTH] is carry-out.
    logic [WIDTH:0]   carryChain;
    logic [WIDTH-1:0] sumBits;
    logic             overflowBit;

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             carry_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             outValid_q;
    logic             outValid_d;

    assign carryChain[0] = adder.cin;

    // Explicit ripple chain: each cell waits on the carry from the one below.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rippleChain
        FullAdderCell u_cell (
            .a_i (adder.a[i]),
            .b_i (adder.b[i]),
            .c_i (carryChain[i]),
            .s_o (sumBits[i]),
            .c_o (carryChain[i+1])
        );
    end

    // Signed overflow: the carry into the sign bit differs from the carry out
    // of it. For WIDTH == 1 the carry into the sign bit is cin itself.
    assign overflowBit = carryChain[WIDTH] ^ carryChain[WIDTH-1];

    // Next-state selection: capture the fresh result only when in_valid is
    // high, otherwise hold, so unknown operands while idle never reach the
    // registers. out_valid simply follows in_valid one cycle later.
    always_comb begin
        sum_d      = sum_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        outValid_d = 1'b0;
        if (adder.in_valid) begin
            sum_d      = sumBits;
            carry_d    = carryChain[WIDTH];
            overflow_d = overflowBit;
            outValid_d = 1'b1;
        end
    end

    // Output registers; reset clears everything immediately and discards any
    // result that was about to be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            outValid_q <= outValid_d;
        end
    end

    assign adder.sum       = sum_q;
    assign adder.carry     = carry_q;
    assign adder.overflow  = overflow_q;
    assign adder.out_valid = outValid_q;

endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// ---------------------------------------------------------------------------
// tb_ripple_carry_adder_4bit
//
// Purpose:
//   Self-checking bench for ripple_carry_adder_4bit (WIDTH = 4): reset
//   behaviour, a table of directed vectors, hold, mid-stream reset,
//   exhaustive operand sweep and randomized traffic against an arithmetic
//   reference model.
// ---------------------------------------------------------------------------
module tb_ripple_carry_adder_4bit;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] expSum;
        logic             expCarry;
        logic             expOverflow;
    } vector_t;

    logic clk;
    logic rst_n;

    int checkCount;
    int failCount;

    // Expected held result for randomized traffic.
    logic [WIDTH-1:0] heldSum;
    logic             heldCarry;
    logic             heldOverflow;

    vector_t vectors[8];

    ripple_carry_adder_4bit_if #(.WIDTH(WIDTH)) adderBus ();

    ripple_carry_adder_4bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .adder (adderBus.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Arithmetic reference: unsigned sum at WIDTH+1 bits, overflow from the
    // signed range of the true two's-complement result.
    function automatic void referenceModel(
        input  logic [WIDTH-1:0] a,
        input  logic [WIDTH-1:0] b,
        input  logic             cin,
        output logic [WIDTH-1:0] expSum,
        output logic             expCarry,
        output logic             expOverflow
    );
        int          signedA;
        int          signedB;
        int          signedTotal;
        logic [WIDTH:0] total;
        total       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        expSum      = total[WIDTH-1:0];
        expCarry    = total[WIDTH];
        signedA     = int'($signed(a));
        signedB     = int'($signed(b));
        signedTotal = signedA + signedB + (cin ? 1 : 0);
        expOverflow = (signedTotal > (2 ** (WIDTH - 1)) - 1) ||
                      (signedTotal < -(2 ** (WIDTH - 1)));
    endfunction

    // Drive operands; called just after a falling edge.
    task automatic applyStimulus(
        input logic             valid,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin
    );
        adderBus.in_valid = valid;
        adderBus.a        = a;
        adderBus.b        = b;
        adderBus.cin      = cin;
    endtask

    // Let one rising edge capture, then return at the following falling edge.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(
        input string            name,
        input logic [WIDTH-1:0] expSum,
        input logic             expCarry,
        input logic             expOverflow,
        input logic             expValid
    );
        checkCount++;
        if (adderBus.sum !== expSum || adderBus.carry !== expCarry ||
            adderBus.overflow !== expOverflow || adderBus.out_valid !== expValid) begin
            failCount++;
            $display("[TB] FAIL %s: got sum=%0d carry=%b ovf=%b valid=%b, expected sum=%0d carry=%b ovf=%b valid=%b",
                     name, adderBus.sum, adderBus.carry, adderBus.overflow, adderBus.out_valid,
                     expSum, expCarry, expOverflow, expValid);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] mSum;
        logic             mCarry;
        logic             mOvf;
        logic             rValid;
        logic [WIDTH-1:0] rA;
        logic [WIDTH-1:0] rB;
        logic             rCin;

        checkCount = 0;
        failCount  = 0;

        vectors[0] = '{a: 4'd0,  b: 4'd0,  cin: 1'b0, expSum: 4'd0,  expCarry: 1'b0, expOverflow: 1'b0};
        vectors[1] = '{a: 4'd1,  b: 4'd2,  cin: 1'b0, expSum: 4'd3,  expCarry: 1'b0, expOverflow: 1'b0};
        vectors[2] = '{a: 4'd5,  b: 4'd3,  cin: 1'b1, expSum: 4'd9,  expCarry: 1'b0, expOverflow: 1'b1};
        vectors[3] = '{a: 4'd15, b: 4'd15, cin: 1'b1, expSum: 4'd15, expCarry: 1'b1, expOverflow: 1'b0};
        vectors[4] = '{a: 4'd10, b: 4'd5,  cin: 1'b0, expSum: 4'd15, expCarry: 1'b0, expOverflow: 1'b0};
        vectors[5] = '{a: 4'd12, b: 4'd3,  cin: 1'b1, expSum: 4'd0,  expCarry: 1'b1, expOverflow: 1'b0};
        vectors[6] = '{a: 4'd7,  b: 4'd1,  cin: 1'b0, expSum: 4'd8,  expCarry: 1'b0, expOverflow: 1'b1};
        vectors[7] = '{a: 4'd8,  b: 4'd8,  cin: 1'b0, expSum: 4'd0,  expCarry: 1'b1, expOverflow: 1'b1};

        // Reset asserted with operands present: outputs clear without a clock edge.
        rst_n = 1'b0;
        applyStimulus(1'b1, 4'd15, 4'd15, 1'b1);
        #2;
        checkOutput("reset_async", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_held_over_edge", 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);

        // Directed table, back-to-back valid operands.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vectors[i].a, vectors[i].b, vectors[i].cin);
            stepCycle();
            checkOutput($sformatf("table_%0d", i), vectors[i].expSum,
                        vectors[i].expCarry, vectors[i].expOverflow, 1'b1);
        end

        // Hold: result 3 stays while operands change with in_valid low.
        applyStimulus(1'b1, 4'd1, 4'd2, 1'b0);
        stepCycle();
        checkOutput("hold_setup", 4'd3, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd9, 4'd9, 1'b0);
        stepCycle();
        checkOutput("hold_cycle1", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
        stepCycle();
        checkOutput("hold_unknown_operands", 4'd3, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset: pending result discarded, first valid after release works.
        applyStimulus(1'b1, 4'd3, 4'd4, 1'b0);
        stepCycle();
        checkOutput("midreset_before", 4'd7, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 4'd6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_async_clear", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midreset_pending_discarded", 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'd2, 4'd2, 1'b0);
        stepCycle();
        checkOutput("midreset_first_valid", 4'd4, 1'b0, 1'b0, 1'b1);

        // Exhaustive sweep of all (a, b, cin) combinations, one per cycle.
        for (int v = 0; v < 512; v++) begin
            logic [8:0] packed9;
            packed9 = 9'(v);
            rA   = packed9[8:5];
            rB   = packed9[4:1];
            rCin = packed9[0];
            applyStimulus(1'b1, rA, rB, rCin);
            stepCycle();
            referenceModel(rA, rB, rCin, mSum, mCarry, mOvf);
            checkOutput($sformatf("exhaustive_a%0d_b%0d_c%0d", rA, rB, rCin),
                        mSum, mCarry, mOvf, 1'b1);
        end
        heldSum      = mSum;
        heldCarry    = mCarry;
        heldOverflow = mOvf;

        // Randomized traffic with random gaps; model tracks the held result.
        for (int r = 0; r < 300; r++) begin
            rValid = 1'($urandom_range(0, 1));
            rA     = 4'($urandom_range(0, 15));
            rB     = 4'($urandom_range(0, 15));
            rCin   = 1'($urandom_range(0, 1));
            applyStimulus(rValid, rA, rB, rCin);
            stepCycle();
            if (rValid) begin
                referenceModel(rA, rB, rCin, heldSum, heldCarry, heldOverflow);
            end
            checkOutput($sformatf("random_%0d", r), heldSum, heldCarry, heldOverflow, rValid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
